// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 host-side sequencer.
package pic_pkg;

   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam logic [7:0] EOI_CMD_DEFAULT = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_READY, S_EOI, S_INTA1, S_INTA_GAP, S_INTA2, S_VEC_WAIT
   } seq_state_e;

   typedef enum logic [2:0] {
      PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD, PH_GAP
   } bus_phase_e;

   typedef enum logic {
      BUS_WRITE, BUS_INTA
   } bus_kind_e;

   typedef enum logic [2:0] {
      W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, W_DONE
   } init_word_e;

   // ICW3 exists only in cascade mode, ICW4 only when ICW1 asks for it.
   function automatic init_word_e next_init_word(input init_word_e cur, input logic [7:0] icw1);
      init_word_e nxt;
      case (cur)
         W_ICW1:  nxt = W_ICW2;
         W_ICW2:  nxt = !icw1[ICW1_SNGL] ? W_ICW3 : (icw1[ICW1_IC4] ? W_ICW4 : W_OCW1);
         W_ICW3:  nxt = icw1[ICW1_IC4] ? W_ICW4 : W_OCW1;
         W_ICW4:  nxt = W_OCW1;
         default: nxt = W_DONE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// One PIC bus transaction: a register write (SETUP/STROBE/HOLD/GAP) or an
// INTA strobe (STROBE/GAP). done is high on the last gap clock so a new go can chain.
module pic_bus_cycle
   import pic_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  bus_kind_e  kind,
   input  logic       a0,
   input  logic [7:0] data,
   output logic       done,
   output logic       strobe_last,
   output logic       idle,
   output logic       cs_n,
   output logic       wr_n,
   output logic       inta_n,
   output logic       bus_a0,
   output logic [7:0] bus_data,
   output logic       bus_oe
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   bus_phase_e    phase, phase_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   bus_kind_e     kind_r;
   logic          load;
   logic          writing;

   assign idle        = (phase == PH_IDLE);
   assign done        = (phase == PH_GAP) && (cnt == GAP_LAST);
   assign strobe_last = (phase == PH_STROBE) && (cnt == PULSE_LAST);

   // Strobes decode straight from registered state so reset releases them at once.
   assign writing = (kind_r == BUS_WRITE) &&
                    (phase == PH_SETUP || phase == PH_STROBE || phase == PH_HOLD);
   assign cs_n    = !writing;
   assign bus_oe  = writing;
   assign wr_n    = !((kind_r == BUS_WRITE) && (phase == PH_STROBE));
   assign inta_n  = !((kind_r == BUS_INTA) && (phase == PH_STROBE));

   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      load      = 1'b0;
      case (phase)
         PH_SETUP: begin
            phase_nxt = PH_STROBE;
            cnt_nxt   = '0;
         end
         PH_STROBE: begin
            if (cnt == PULSE_LAST) begin
               cnt_nxt   = '0;
               phase_nxt = (kind_r == BUS_WRITE) ? PH_HOLD : PH_GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PH_HOLD: begin
            phase_nxt = PH_GAP;
            cnt_nxt   = '0;
         end
         PH_GAP: begin
            if (cnt == GAP_LAST) phase_nxt = PH_IDLE;
            else cnt_nxt = cnt + 1'b1;
         end
         default: ;
      endcase
      if (go && (idle || done)) begin
         load      = 1'b1;
         cnt_nxt   = '0;
         phase_nxt = (kind == BUS_WRITE) ? PH_SETUP : PH_STROBE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase    <= PH_IDLE;
         cnt      <= '0;
         kind_r   <= BUS_WRITE;
         bus_a0   <= 1'b0;
         bus_data <= 8'h00;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         if (load) begin
            kind_r <= kind;
            if (kind == BUS_WRITE) begin
               bus_a0   <= a0;
               bus_data <= data;
            end
         end
      end
   end

endmodule

// File: rtl/pic_host_sequencer.sv
// Host bus master for the 8259: runs the ICW/OCW1 init sequence, then services
// interrupts with an INTA pair, a vector handshake and queued EOI writes.
module pic_host_sequencer
   import pic_pkg::*;
#(
   parameter int         PULSE_CYCLES = 2,
   parameter int         GAP_CYCLES   = 1,
   parameter logic [7:0] EOI_CMD      = EOI_CMD_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] icw1,
   input  logic [7:0] icw2,
   input  logic [7:0] icw3,
   input  logic [7:0] icw4,
   input  logic [7:0] ocw1,
   input  logic       eoi_req,
   output logic       busy,
   output logic       init_done,
   output logic       pic_cs_n,
   output logic       pic_rd_n,
   output logic       pic_wr_n,
   output logic       pic_a0,
   output logic [7:0] pic_data_out,
   output logic       pic_data_oe,
   input  logic [7:0] pic_data_in,
   output logic       pic_inta_n,
   input  logic       pic_int,
   output logic       vec_valid,
   output logic [7:0] vec_data,
   input  logic       vec_ready
);

   seq_state_e state, state_nxt;
   init_word_e word, word_nxt;
   logic [7:0] icw1_r, icw2_r, icw3_r, icw4_r, ocw1_r;
   logic       eoi_pending, int_meta, int_sync;
   logic       accept_start, capture_vec, eoi_done;
   logic       bus_go, bus_done, bus_strobe_last, bus_idle, bus_a0_req;
   bus_kind_e  bus_kind;
   logic [7:0] bus_data_req;

   assign busy      = (state == S_INIT);
   assign init_done = !(state == S_IDLE || state == S_INIT);
   assign vec_valid = (state == S_VEC_WAIT);
   assign pic_rd_n  = 1'b1;

   pic_bus_cycle #(
      .PULSE_CYCLES (PULSE_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
   ) u_bus (
      .clock       (clock),
      .reset       (reset),
      .go          (bus_go),
      .kind        (bus_kind),
      .a0          (bus_a0_req),
      .data        (bus_data_req),
      .done        (bus_done),
      .strobe_last (bus_strobe_last),
      .idle        (bus_idle),
      .cs_n        (pic_cs_n),
      .wr_n        (pic_wr_n),
      .inta_n      (pic_inta_n),
      .bus_a0      (pic_a0),
      .bus_data    (pic_data_out),
      .bus_oe      (pic_data_oe)
   );

   // Next-state logic; the first init word comes straight from the inputs because
   // the word registers only load on the accepting edge.
   always_comb begin
      state_nxt    = state;
      word_nxt     = word;
      bus_go       = 1'b0;
      bus_kind     = BUS_WRITE;
      bus_a0_req   = 1'b1;
      bus_data_req = 8'h00;
      accept_start = 1'b0;
      capture_vec  = 1'b0;
      eoi_done     = 1'b0;
      case (state)
         S_IDLE: accept_start = start;
         S_INIT: begin
            if (bus_done) begin
               word_nxt = next_init_word(word, icw1_r);
               if (word_nxt == W_DONE) begin
                  state_nxt = S_READY;
               end else begin
                  bus_go = 1'b1;
                  case (word_nxt)
                     W_ICW2:  bus_data_req = icw2_r;
                     W_ICW3:  bus_data_req = icw3_r;
                     W_ICW4:  bus_data_req = icw4_r;
                     default: bus_data_req = ocw1_r;
                  endcase
               end
            end
         end
         S_READY: begin
            if (bus_idle) begin
               if (start) begin
                  accept_start = 1'b1;
               end else if (eoi_pending) begin
                  bus_go       = 1'b1;
                  bus_a0_req   = 1'b0;
                  bus_data_req = EOI_CMD;
                  state_nxt    = S_EOI;
               end else if (int_sync) begin
                  bus_go    = 1'b1;
                  bus_kind  = BUS_INTA;
                  state_nxt = S_INTA1;
               end
            end
         end
         S_EOI: begin
            if (bus_done) begin
               eoi_done  = 1'b1;
               state_nxt = S_READY;
            end
         end
         S_INTA1: if (bus_strobe_last) state_nxt = S_INTA_GAP;
         S_INTA_GAP: begin
            if (bus_done) begin
               bus_go    = 1'b1;
               bus_kind  = BUS_INTA;
               state_nxt = S_INTA2;
            end
         end
         S_INTA2: begin
            if (bus_strobe_last) begin
               capture_vec = 1'b1;
               state_nxt   = S_VEC_WAIT;
            end
         end
         S_VEC_WAIT: if (vec_ready) state_nxt = S_READY;
         default: state_nxt = S_IDLE;
      endcase
      if (accept_start) begin
         bus_go       = 1'b1;
         bus_kind     = BUS_WRITE;
         bus_a0_req   = 1'b0;
         bus_data_req = icw1;
         word_nxt     = W_ICW1;
         state_nxt    = S_INIT;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         word   <= W_ICW1;
         icw1_r <= 8'h00;
         icw2_r <= 8'h00;
         icw3_r <= 8'h00;
         icw4_r <= 8'h00;
         ocw1_r <= 8'h00;
      end else begin
         state <= state_nxt;
         word  <= word_nxt;
         if (accept_start) begin
            icw1_r <= icw1;
            icw2_r <= icw2;
            icw3_r <= icw3;
            icw4_r <= icw4;
            ocw1_r <= ocw1;
         end
      end
   end

   // A request arriving as an EOI write completes wins, so it is not lost.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         int_meta    <= 1'b0;
         int_sync    <= 1'b0;
         eoi_pending <= 1'b0;
         vec_data    <= 8'h00;
      end else begin
         int_meta <= pic_int;
         int_sync <= int_meta;
         if (capture_vec) vec_data <= pic_data_in;
         if (accept_start) eoi_pending <= 1'b0;
         else if (eoi_req && init_done) eoi_pending <= 1'b1;
         else if (eoi_done) eoi_pending <= 1'b0;
      end
   end

endmodule
